// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;
  localparam int WB_DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Two-entry result FIFO: registered head/tail pointers and a 0..2 occupancy count.
module wb_fifo
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  wb_entry_t  push_data_i,
  input  logic       pop_i,
  output logic [1:0] count_o,
  output wb_entry_t  head_o
);
  wb_entry_t  mem_q [WB_DEPTH];
  logic       head_q, tail_q;
  logic [1:0] count_q;

  // One-bit pointers wrap 1->0 on increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i)  head_q <= head_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[head_q];
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: LSU-priority arbitration, 2-deep queue, registered RF write port.
// Optional WB_BYPASS_EN forwards the in-flight write to the rs1/rs2 operand paths.
module wb_stage
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        hold,
  output logic [4:0]  rd,
  output logic [31:0] rd_d,
  output logic        wr,
  output logic        busy,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] rs1_rf,
  input  logic [31:0] rs2_rf,
  output logic [31:0] rs1_fwd,
  output logic [31:0] rs2_fwd
);
  logic [1:0]  count;
  wb_entry_t   head, in_e;
  logic        lsu_push, alu_push, push, pop, thru, fifo_push;
  logic        wr_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;

  // Full means not ready, even if the head drains this same cycle.
  assign lsu_ready = !rst && (count < 2'(WB_DEPTH));
  assign alu_ready = lsu_ready && !lsu_valid;
  assign lsu_push  = lsu_valid && lsu_ready;
  assign alu_push  = alu_valid && alu_ready;
  assign push      = lsu_push || alu_push;
  assign in_e      = lsu_push ? wb_entry_t'{rd: lsu_rd, data: lsu_data}
                              : wb_entry_t'{rd: alu_rd, data: alu_data};

  assign pop       = !hold && (count != 2'd0);
  assign thru      = !hold && (count == 2'd0) && push;
  assign fifo_push = push && !thru;

  wb_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (in_e),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  // rd==0 entries are consumed but never raise the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= 1'b0;
      rd_q   <= 5'd0;
      data_q <= 32'd0;
    end else begin
      wr_q <= 1'b0;
      if (pop) begin
        rd_q   <= head.rd;
        data_q <= head.data;
        wr_q   <= (head.rd != 5'd0);
      end else if (thru) begin
        rd_q   <= in_e.rd;
        data_q <= in_e.data;
        wr_q   <= (in_e.rd != 5'd0);
      end
    end
  end

  assign wr   = wr_q;
  assign rd   = rd_q;
  assign rd_d = data_q;
  assign busy = (count != 2'd0) || wr_q;

`ifdef WB_BYPASS_EN
  assign rs1_fwd = (wr_q && (rd_q == rs1) && (rs1 != 5'd0)) ? data_q : rs1_rf;
  assign rs2_fwd = (wr_q && (rd_q == rs2) && (rs2 != 5'd0)) ? data_q : rs2_rf;
`else
  assign rs1_fwd = rs1_rf;
  assign rs2_fwd = rs2_rf;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Random + directed bench for wb_stage against a queue-based reference model.
module tb_wb_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst, hold, alu_valid, lsu_valid;
  logic        alu_ready, lsu_ready, wr, busy;
  logic [4:0]  alu_rd, lsu_rd, rd, rs1, rs2;
  logic [31:0] alu_data, lsu_data, rd_d, rs1_rf, rs2_rf, rs1_fwd, rs2_fwd;

  int vectors = 0;
  int errors  = 0;

  wb_entry_t   mq[$];
  logic        m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .hold(hold), .rd(rd), .rd_d(rd_d), .wr(wr), .busy(busy),
    .rs1(rs1), .rs2(rs2), .rs1_rf(rs1_rf), .rs2_rf(rs2_rf),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd_exp(input logic [4:0] rs, input logic [31:0] rf);
`ifdef WB_BYPASS_EN
    return (m_wr && m_rd == rs && rs != 0) ? m_data : rf;
`else
    return rf;
`endif
  endfunction

  task automatic compare();
    logic rdy;
    rdy = !rst && (mq.size() < 2);
    chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, rdy});
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, rdy && !lsu_valid});
    chk("wr",   {31'd0, wr},   {31'd0, m_wr});
    chk("busy", {31'd0, busy}, {31'd0, (mq.size() != 0) || m_wr});
    if (m_wr) begin
      chk("rd",   {27'd0, rd}, {27'd0, m_rd});
      chk("rd_d", rd_d, m_data);
    end
    chk("rs1_fwd", rs1_fwd, fwd_exp(rs1, rs1_rf));
    chk("rs2_fwd", rs2_fwd, fwd_exp(rs2, rs2_rf));
  endtask

  // Reference behaviour at a clock edge, from pre-edge model state and inputs.
  task automatic model_edge();
    bit        acc;
    wb_entry_t e, h;
    acc = 0;
    if (rst) begin
      mq.delete();
      m_wr = 0; m_rd = 0; m_data = 0;
      return;
    end
    if (mq.size() < 2) begin
      if (lsu_valid)      begin acc = 1; e.rd = lsu_rd; e.data = lsu_data; end
      else if (alu_valid) begin acc = 1; e.rd = alu_rd; e.data = alu_data; end
    end
    m_wr = 0;
    if (!hold && mq.size() > 0) begin
      h = mq.pop_front();
      m_rd = h.rd; m_data = h.data; m_wr = (h.rd != 0);
      if (acc) mq.push_back(e);
    end else if (!hold && acc) begin
      m_rd = e.rd; m_data = e.data; m_wr = (e.rd != 0);
    end else if (acc) begin
      mq.push_back(e);
    end
  endtask

  task automatic cycle();
    #1 compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; hold = 0; alu_valid = 0; lsu_valid = 0;
    alu_rd = 0; alu_data = 0; lsu_rd = 0; lsu_data = 0;
    rs1 = 0; rs2 = 0; rs1_rf = 0; rs2_rf = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    m_wr = 0; m_rd = 0; m_data = 0;
    @(negedge clk);
    cycle();
    #1;
    chk("reset_wr",   {31'd0, wr},   32'd0);
    chk("reset_rd",   {27'd0, rd},   32'd0);
    chk("reset_rd_d", rd_d,          32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready_in_rst", {31'd0, lsu_ready}, 32'd0);
    rst = 0;

    // Write-through of an ALU result into an idle stage.
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cycle();
    idle();
    #1;
    chk("thru_wr",   {31'd0, wr},   32'd1);
    chk("thru_rd",   {27'd0, rd},   32'd5);
    chk("thru_rd_d", rd_d,          32'hDEADBEEF);
    chk("thru_busy", {31'd0, busy}, 32'd1);
    cycle();
    chk("thru_wr_after", {31'd0, wr}, 32'd0);

    // LSU wins; ALU stalls then follows.
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h11;
    alu_valid = 1; alu_rd = 4; alu_data = 32'h22;
    #1 chk("prio_alu_ready", {31'd0, alu_ready}, 32'd0);
    cycle();
    chk("prio_first_rd", {27'd0, rd}, 32'd3);
    chk("prio_first_d",  rd_d,        32'h11);
    lsu_valid = 0;
    cycle();
    alu_valid = 0;
    chk("prio_second_rd", {27'd0, rd}, 32'd4);
    chk("prio_second_d",  rd_d,        32'h22);
    cycle();

    // Hold fills the queue; third push refused; drain in order.
    hold = 1; lsu_valid = 1;
    lsu_rd = 10; lsu_data = 32'hA0; cycle();
    lsu_rd = 11; lsu_data = 32'hA1; cycle();
    lsu_rd = 12; lsu_data = 32'hA2;
    #1 chk("hold_full_ready", {31'd0, lsu_ready}, 32'd0);
    chk("hold_wr", {31'd0, wr}, 32'd0);
    cycle();
    idle();
    cycle();
    chk("drain1_wr", {31'd0, wr}, 32'd1);
    chk("drain1_rd", {27'd0, rd}, 32'd10);
    cycle();
    chk("drain2_wr", {31'd0, wr}, 32'd1);
    chk("drain2_rd", {27'd0, rd}, 32'd11);
    cycle();
    chk("drain_done_wr", {31'd0, wr}, 32'd0);

    // rd==0 is consumed silently.
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    cycle();
    idle();
    chk("x0_wr", {31'd0, wr}, 32'd0);
    cycle();
    chk("x0_busy", {31'd0, busy}, 32'd0);

    // Reset with a full queue discards both entries.
    hold = 1; lsu_valid = 1; lsu_rd = 20; lsu_data = 32'hB0; cycle();
    lsu_rd = 21; lsu_data = 32'hB1; cycle();
    chk("full_busy", {31'd0, busy}, 32'd1);
    idle(); rst = 1;
    #1 chk("rst_ready", {31'd0, lsu_ready | alu_ready}, 32'd0);
    cycle();
    rst = 0;
    chk("rst_wr",   {31'd0, wr},   32'd0);
    chk("rst_rd",   {27'd0, rd},   32'd0);
    chk("rst_rd_d", rd_d,          32'd0);
    #1 chk("rst_ready_after", {31'd0, lsu_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_no_stale", {31'd0, wr}, 32'd0);
    end

    // Operand forwarding from the in-flight write.
    alu_valid = 1; alu_rd = 7; alu_data = 32'hCAFE0000;
    cycle();
    idle();
    rs1 = 7; rs2 = 0; rs1_rf = 32'h1; rs2_rf = 32'h1234;
    #1;
`ifdef WB_BYPASS_EN
    chk("fwd_rs1", rs1_fwd, 32'hCAFE0000);
`else
    chk("fwd_rs1", rs1_fwd, 32'h1);
`endif
    chk("fwd_rs2", rs2_fwd, 32'h1234);
    cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      hold      = ($urandom_range(0, 2) == 0);
      alu_valid = $urandom_range(0, 1);
      lsu_valid = ($urandom_range(0, 2) == 0);
      alu_rd    = 5'($urandom_range(0, 7));
      lsu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      lsu_data  = $urandom;
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      rs1_rf    = $urandom;
      rs2_rf    = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports, one per line, in this order (name  direction  width  meaning); clock and reset first.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 alu_valid  input  1  ALU result offered.
REQ-005 alu_ready  output  1  ALU result accepted this cycle when alu_valid high.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result value.
REQ-008 lsu_valid / lsu_ready / lsu_rd / lsu_data  in/out/in/in  1/1/5/32  load-unit result, same rules as ALU.
REQ-009 hold  input  1  register-file write port unavailable this cycle.
REQ-010 rd  output  5  register-file write address.
REQ-011 rd_d  output  32  register-file write data.
REQ-012 wr  output  1  register-file write enable.
REQ-013 busy  output  1  high when any result is queued or being written.
REQ-014 rs1 / rs2  input  5 each  operand addresses, as sent to the register file.
REQ-015 rs1_rf / rs2_rf  input  32 each  register-file read data.
REQ-016 rs1_fwd / rs2_fwd  output  32 each  operand data delivered to execute.

Function
REQ-017 SHALL keep a 2-entry FIFO of {rd, data}, with a count of 0..2 and head/tail pointers that wrap 1->0.
REQ-018 SHALL accept at most one result per cycle; LSU has fixed priority over ALU.
REQ-019 lsu_ready = (count<2); alu_ready = (count<2) && !lsu_valid; both combinational; a push happens only on valid&&ready.
REQ-020 Pop: each cycle with hold low and count>0, the head loads the output registers; wr=1 unless head rd==0 (then wr=0, entry still consumed).
REQ-021 Write-through: with count==0, hold low and a push, the entry SHALL go directly to the output registers, bypassing the FIFO; wr is high in the cycle after acceptance (latency 1).
REQ-022 Otherwise, with hold low and nothing to pop, the next wr SHALL be 0; rd/rd_d hold their last values.
REQ-023 With hold high, the next wr SHALL be 0; no pop occurs; a push still enters the FIFO when count<2.
REQ-024 A simultaneous push and pop with count 1 or 2 SHALL leave count unchanged and preserve order (FIFO, never reordered).
REQ-025 With count==2, ready SHALL be low even if a pop occurs in the same cycle (no pass-through when full).
REQ-026 busy = (count!=0) || wr.
REQ-027 With the feature off, rs1_fwd = rs1_rf and rs2_fwd = rs2_rf.

Reset
REQ-028 rst high at a clock edge SHALL set count=0, pointers=0, wr=0, rd=0, rd_d=0; queued results are discarded, including mid-operation.
REQ-029 During rst, alu_ready and lsu_ready SHALL read 0.

Configuration
REQ-030 Macro WB_BYPASS_EN, when defined: rsN_fwd = rd_d if (wr && rd==rsN && rsN!=0), else rsN_rf; applies independently to N=1 and N=2.
REQ-031 When WB_BYPASS_EN is undefined, REQ-027 applies and no comparator logic is built.

Structure
REQ-032 Package wb_pkg SHALL hold typedef wb_entry_t {logic[4:0] rd; logic[31:0] data} and constant WB_DEPTH=2.
REQ-033 The FIFO SHALL be a sub-module wb_fifo (push/pop/count/head); arbitration, output registers and bypass live in wb_stage.

Verification
REQ-034 Bench SHALL cover: ALU push rd=5, data=0xDEADBEEF, idle FIFO -> next cycle wr=1, rd=5, rd_d=0xDEADBEEF, busy=1; the cycle after, wr=0.
REQ-035 Bench SHALL cover: alu_valid and lsu_valid both high (lsu rd=3, data=0x11; alu rd=4, data=0x22) -> lsu accepted first, alu_ready=0; the ALU result is written in a later cycle in order 3 then 4.
REQ-036 Bench SHALL cover: hold=1 and three LSU pushes -> first two accepted, lsu_ready=0 on the third, wr stays 0; release hold -> writes on two consecutive cycles in push order.
REQ-037 Bench SHALL cover: push rd=0, data=0x55 -> consumed, wr never asserts, busy returns to 0 after 1 cycle.
REQ-038 Bench SHALL cover: rst asserted with count=2 -> next cycle count=0, wr=0, rd=0, rd_d=0, ready=1 after rst drops; stale entries are never written.
REQ-039 Bench SHALL cover, with WB_BYPASS_EN: wr=1, rd=7, rd_d=0xCAFE0000, rs1=7, rs2=0, rs1_rf=0x1 -> rs1_fwd=0xCAFE0000, rs2_fwd=rs2_rf; without the macro, rs1_fwd=0x1.
